// File: rtl/if_fetch_stage.sv
// LEGv8 instruction fetch: PC register plus IF/ID pipeline register; optional perf counters under IF_FETCH_PERF_EN.
// Latency: instruction at pc_out appears on if_id_instr one edge later.
// Backpressure: pc_write/if_id_write hold PC and IF/ID independently; branch_taken redirects and flushes.
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic [31:0] instr_in,
    output logic [63:0] pc_out,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        fetch_fault
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    // MEM_BYTES is a power of two, so wrapping reduces to masking.
    localparam logic [63:0] ADDR_MASK = 64'(MEM_BYTES - 1);
    localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

    logic [63:0] pcInc;
    logic [63:0] pcBranch;
    logic        targetBad;

    always_comb begin
        pcInc     = (pc_out + 64'd4) & ADDR_MASK;
        pcBranch  = {branch_target[63:2], 2'b00} & ADDR_MASK;
        targetBad = (branch_target[1:0] != 2'b00) || (branch_target >= MEM_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out <= RESET_PC;
        end else if (branch_taken) begin
            pc_out <= pcBranch;
        end else if (pc_write) begin
            pc_out <= pcInc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_pc    <= 64'd0;
            if_id_instr <= 32'h0;
            if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            if_id_pc    <= 64'd0;
            if_id_instr <= 32'h0;
            if_id_valid <= 1'b0;
        end else if (if_id_write) begin
            if_id_pc    <= pc_out;
            if_id_instr <= instr_in;
            if_id_valid <= 1'b1;
        end
    end

    // Sticky until reset; the redirect itself still uses the sanitised address.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_fault <= 1'b0;
        end else if (branch_taken && targetBad) begin
            fetch_fault <= 1'b1;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic fetchEvt;
    logic stallEvt;

    always_comb begin
        fetchEvt = !branch_taken && if_id_write;
        stallEvt = !branch_taken && !pc_write;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (fetchEvt && (perf_fetch_cnt != 32'hFFFFFFFF)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (stallEvt && (perf_stall_cnt != 32'hFFFFFFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (branch_taken && (perf_flush_cnt != 32'hFFFFFFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; perf counter checks compile in when IF_FETCH_PERF_EN is defined.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        if_id_write;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] instr_in;
    logic [63:0] pc_out;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_fault;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    logic [31:0] imem [16];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign instr_in = imem[pc_out[5:2]];

    if_fetch_stage #(.RESET_PC(64'd0), .MEM_BYTES(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .fetch_fault   (fetch_fault)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) imem[i] = 32'hD503201F;
        imem[0]  = 32'hF842802A;
        imem[1]  = 32'hCB03004B;
        imem[2]  = 32'h8B040085;
        imem[10] = 32'hCB030022;
        imem[15] = 32'h17FFFFF1;

        reset = 1'b1; pc_write = 1'b0; if_id_write = 1'b0;
        branch_taken = 1'b0; branch_target = 64'd0;
        #2;
        step();
        check("rst_pc", pc_out, 64'd0);
        check("rst_ifid_pc", if_id_pc, 64'd0);
        check("rst_instr", {32'd0, if_id_instr}, 64'h0);
        check("rst_valid", {63'd0, if_id_valid}, 64'd0);
        check("rst_fault", {63'd0, fetch_fault}, 64'd0);

        // Sequential fetch
        reset = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
        step();
        check("seq1_pc", pc_out, 64'd4);
        check("seq1_ifid_pc", if_id_pc, 64'd0);
        check("seq1_instr", {32'd0, if_id_instr}, 64'hF842802A);
        check("seq1_valid", {63'd0, if_id_valid}, 64'd1);
        step();
        check("seq2_pc", pc_out, 64'd8);
        check("seq2_ifid_pc", if_id_pc, 64'd4);
        check("seq2_instr", {32'd0, if_id_instr}, 64'hCB03004B);

        // Full stall at pc 8
        pc_write = 1'b0; if_id_write = 1'b0;
        step();
        check("stall1_pc", pc_out, 64'd8);
        check("stall1_ifid_pc", if_id_pc, 64'd4);
        step();
        check("stall2_pc", pc_out, 64'd8);
        check("stall2_ifid_pc", if_id_pc, 64'd4);
        check("stall2_valid", {63'd0, if_id_valid}, 64'd1);
        pc_write = 1'b1; if_id_write = 1'b1;
        step();
        check("rel_pc", pc_out, 64'd12);
        check("rel_ifid_pc", if_id_pc, 64'd8);
        check("rel_instr", {32'd0, if_id_instr}, 64'h8B040085);

        // Taken branch with flush overriding if_id_write=0
        branch_taken = 1'b1; branch_target = 64'd40; if_id_write = 1'b0;
        step();
        check("br_pc", pc_out, 64'd40);
        check("br_valid", {63'd0, if_id_valid}, 64'd0);
        check("br_instr", {32'd0, if_id_instr}, 64'h0);
        check("br_ifid_pc", if_id_pc, 64'd0);
        check("br_fault", {63'd0, fetch_fault}, 64'd0);
        branch_taken = 1'b0; if_id_write = 1'b1;
        step();
        check("br_next_pc", pc_out, 64'd44);
        check("br_next_ifid_pc", if_id_pc, 64'd40);
        check("br_next_instr", {32'd0, if_id_instr}, 64'hCB030022);
        check("br_next_valid", {63'd0, if_id_valid}, 64'd1);

        // Wrap 60 -> 0
        repeat (4) step();
        check("pre_wrap_pc", pc_out, 64'd60);
        step();
        check("wrap_pc", pc_out, 64'd0);
        check("wrap_ifid_pc", if_id_pc, 64'd60);
        check("wrap_instr", {32'd0, if_id_instr}, 64'h17FFFFF1);
        check("wrap_fault", {63'd0, fetch_fault}, 64'd0);

        // Misaligned target: redirect aligned, fault set
        branch_taken = 1'b1; branch_target = 64'h2A;
        step();
        check("mis_pc", pc_out, 64'h28);
        check("mis_fault", {63'd0, fetch_fault}, 64'd1);
        branch_taken = 1'b0;
        step();
        check("mis_sticky_pc", pc_out, 64'h2C);
        check("mis_sticky_fault", {63'd0, fetch_fault}, 64'd1);
        // Out-of-range target wraps
        branch_taken = 1'b1; branch_target = 64'h80;
        step();
        check("oor_pc", pc_out, 64'd0);
        check("oor_fault", {63'd0, fetch_fault}, 64'd1);
        // Good redirect while pc_write=0 still moves PC, fault stays
        branch_target = 64'd8; pc_write = 1'b0;
        step();
        check("good_br_pc", pc_out, 64'd8);
        check("good_br_fault", {63'd0, fetch_fault}, 64'd1);
        branch_taken = 1'b0; pc_write = 1'b1;
        reset = 1'b1;
        step();
        check("fault_clr", {63'd0, fetch_fault}, 64'd0);
        check("fault_clr_pc", pc_out, 64'd0);

        // Stall with if_id_write=1 re-captures the same PC
        reset = 1'b0;
        step();
        check("st2_pc", pc_out, 64'd4);
        pc_write = 1'b0;
        step();
        check("recap1_pc", pc_out, 64'd4);
        check("recap1_ifid_pc", if_id_pc, 64'd4);
        check("recap1_instr", {32'd0, if_id_instr}, 64'hCB03004B);
        step();
        check("recap2_ifid_pc", if_id_pc, 64'd4);
        check("recap2_valid", {63'd0, if_id_valid}, 64'd1);

        // Reset wins over concurrent redirect and stall
        reset = 1'b1; branch_taken = 1'b1; branch_target = 64'd40; pc_write = 1'b0;
        step();
        check("rstmid_pc", pc_out, 64'd0);
        check("rstmid_valid", {63'd0, if_id_valid}, 64'd0);
        check("rstmid_fault", {63'd0, fetch_fault}, 64'd0);
        branch_taken = 1'b0;

`ifdef IF_FETCH_PERF_EN
        step();
        check("perf_rst_fetch", {32'd0, perf_fetch_cnt}, 64'd0);
        reset = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
        repeat (5) step();
        pc_write = 1'b0; if_id_write = 1'b0;
        repeat (2) step();
        branch_taken = 1'b1; branch_target = 64'd0; pc_write = 1'b1;
        step();
        branch_taken = 1'b0;
        check("perf_fetch", {32'd0, perf_fetch_cnt}, 64'd5);
        check("perf_stall", {32'd0, perf_stall_cnt}, 64'd2);
        check("perf_flush", {32'd0, perf_flush_cnt}, 64'd1);
        force dut.perf_stall_cnt = 32'hFFFFFFFF;
        #1;
        release dut.perf_stall_cnt;
        pc_write = 1'b0;
        step();
        check("perf_stall_sat", {32'd0, perf_stall_cnt}, 64'hFFFFFFFF);
        check("perf_flush_hold", {32'd0, perf_flush_cnt}, 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
